axi_wdata_chs: RTL and testbench
================================

Name: axi_wdata_chs

Overview:
- AXI write-data and write-response path of the AXI MMU wrapper; the write-direction counterpart of the read-data channel.
- Forwards W beats from the app/interconnect (slave-side) to the memory controller (master-side) through a FIFO, and passes B responses back.
- On a translation-fault `drop` from the address channel, it sinks the faulting burst's W beats without forwarding them, then returns a locally generated DECERR B response.

Parameters:
- BUF_SZ, 256, depth in beats of the W FIFO
- ID_WID, 8, AXI ID width
- DATA_WID, 32, W data width (multiple of 8)
- USER_WID, 2, AXI user width

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high reset
- in_wdata  in  DATA_WID  write data from app
- in_wstrb  in  DATA_WID/8  byte strobes from app
- in_wlast  in  1  last beat of burst
- in_swvalid  in  1  W valid from app
- out_swready  out  1  W ready to app
- out_wdata  out  DATA_WID  write data to MC
- out_wstrb  out  DATA_WID/8  strobes to MC
- out_wlast  out  1  last beat to MC
- out_mwvalid  out  1  W valid to MC
- in_mwready  in  1  W ready from MC
- in_bid  in  ID_WID  B id from MC
- in_bresp  in  2  B resp from MC
- in_buser  in  USER_WID  B user from MC
- in_mbvalid  in  1  B valid from MC
- out_mbready  out  1  B ready to MC
- out_bid  out  ID_WID  B id to app
- out_bresp  out  2  B resp to app
- out_buser  out  USER_WID  B user to app
- out_sbvalid  out  1  B valid to app
- in_sbready  in  1  B ready from app
- in_awid  in  ID_WID  id of faulting burst, valid with drop
- in_awuser  in  USER_WID  user of faulting burst, valid with drop
- in_awlen  in  8  AXI len (beats-1) of faulting burst, valid with drop
- drop  in  1  one-cycle pulse: next burst on W is to be discarded
- drop_done  out  1  one-cycle pulse: drop B response handshaken

Behaviour:
- Reset (reset=1 at a clk edge):
  - All outputs = 0.
  - FIFO flushed; state=PASS; in_burst=0; drop_pend=0; counter=0.
  - Applies mid-burst too: partial bursts and pending B responses are discarded.
- FIFO: width DATA_WID+DATA_WID/8+1 holding {wdata, wstrb, wlast}; registered read.
- States:
  - PASS: forward W traffic (normal operation).
  - SINK: discard the faulting burst's W beats.
  - BRESP: return the locally generated DECERR B response.
- PASS:
  - out_swready = ~fifo_full.
  - Push on in_swvalid & out_swready.
  - in_burst set on an accepted beat with wlast=0; cleared on an accepted beat with wlast=1.
- Drop capture:
  - On drop=1, latch awid/awuser/awlen into *_q and set drop_pend (single-entry).
  - Upstream issues at most one outstanding drop; a further drop while drop_pend=1 or state!=PASS is ignored.
- PASS->SINK: in the cycle after drop_pend=1 and in_burst=0 and no beat is being accepted. A drop coinciding with a wlast=1 acceptance takes effect the next cycle; that beat is forwarded.
- SINK:
  - out_swready=1; beats are discarded, never written to the FIFO.
  - cnt increments per accepted beat.
  - On the accepted beat with cnt==awlen_q, go to BRESP and clear cnt and drop_pend.
  - in_wlast is ignored in SINK; the count rules.
- BRESP:
  - out_swready=0; out_mbready=0.
  - When the B output register is empty or being consumed, load {awid_q, DECERR=2'b11, awuser_q} with out_sbvalid=1.
  - On the handshake of that response: drop_done=1 for one cycle, return to PASS.
- FIFO drain to MC, independent of state, continues during SINK/BRESP:
  - The output register loads when FIFO is non-empty and (~out_mwvalid | in_mwready).
  - out_mwvalid is held with data stable while in_mwready=0.
  - Latency: beat accepted at cycle N with FIFO empty and output idle -> out_mwvalid at N+2.
  - Throughput: 1 beat/cycle sustained.
- B passthrough:
  - out_mbready = (~out_sbvalid | in_sbready) & (state!=BRESP).
  - Registered, 1-cycle latency; out_b* held stable while out_sbvalid & ~in_sbready.
- Full: after BUF_SZ unread beats, out_swready=0 in PASS until one beat drains. There is no loss and no duplication.
- Empty: out_mwvalid drops after the last beat handshake if the FIFO is empty.

Test Plan:
- 4-beat burst (wdata 1..4, wlast on beat 4), in_mwready=1 -> out_mwvalid first at +2 cycles, data 1..4 in order, out_wlast only on beat 4.
- Hold in_mwready=0 with 256+2 beats offered -> out_swready falls after FIFO full; release -> all beats emerge in order, none lost.
- drop with awid=8'h5A, awuser=2'b01, awlen=3, then 4 beats -> out_mwvalid stays 0 for them; out_sbvalid with bid=8'h5A, bresp=2'b11, buser=2'b01; drop_done pulses on the handshake.
- drop asserted mid-burst (beat 2 of 4) -> remaining beats 3,4 forwarded, the following burst sunk, DECERR B returned.
- MC B (bid=3, OKAY) arriving during BRESP with in_sbready=0 -> out_mbready=0 until the DECERR response is taken; then bid=3 passes through unchanged.
- reset=1 mid-SINK after 2 beats -> all outputs 0 the next cycle; a new normal burst forwards correctly afterwards.

Source files
------------

// File: rtl/axi_wdata_chs_if.sv
// W and B channel bundle between the app side, the write-data path and the memory controller.
// slave = the write-data path's view, master = the environment driving it.
interface axi_wdata_chs_if #(
    parameter int ID_WID   = 8,
    parameter int DATA_WID = 32,
    parameter int USER_WID = 2
);
    logic [DATA_WID-1:0]   in_wdata;
    logic [DATA_WID/8-1:0] in_wstrb;
    logic                  in_wlast;
    logic                  in_swvalid;
    logic                  out_swready;

    logic [DATA_WID-1:0]   out_wdata;
    logic [DATA_WID/8-1:0] out_wstrb;
    logic                  out_wlast;
    logic                  out_mwvalid;
    logic                  in_mwready;

    logic [ID_WID-1:0]     in_bid;
    logic [1:0]            in_bresp;
    logic [USER_WID-1:0]   in_buser;
    logic                  in_mbvalid;
    logic                  out_mbready;

    logic [ID_WID-1:0]     out_bid;
    logic [1:0]            out_bresp;
    logic [USER_WID-1:0]   out_buser;
    logic                  out_sbvalid;
    logic                  in_sbready;

    modport slave (
        input  in_wdata, in_wstrb, in_wlast, in_swvalid, in_mwready,
        input  in_bid, in_bresp, in_buser, in_mbvalid, in_sbready,
        output out_swready, out_wdata, out_wstrb, out_wlast, out_mwvalid,
        output out_mbready, out_bid, out_bresp, out_buser, out_sbvalid
    );

    modport master (
        output in_wdata, in_wstrb, in_wlast, in_swvalid, in_mwready,
        output in_bid, in_bresp, in_buser, in_mbvalid, in_sbready,
        input  out_swready, out_wdata, out_wstrb, out_wlast, out_mwvalid,
        input  out_mbready, out_bid, out_bresp, out_buser, out_sbvalid
    );
endinterface

// File: rtl/axi_wdata_chs.sv
// AXI write-data / write-response path: W beats buffered to the MC, B passed back,
// and translation-fault bursts sunk locally with a generated DECERR response.
//   state    | meaning
//   ST_PASS  | forward W beats into the FIFO, pass MC B responses through
//   ST_SINK  | swallow the faulting burst, counted by awlen
//   ST_BRESP | return the local DECERR response, MC B channel blocked
module axi_wdata_chs #(
    parameter int BUF_SZ   = 256,
    parameter int ID_WID   = 8,
    parameter int DATA_WID = 32,
    parameter int USER_WID = 2
) (
    input  logic                clk,
    input  logic                reset,
    axi_wdata_chs_if.slave      bus,
    input  logic [ID_WID-1:0]   in_awid,
    input  logic [USER_WID-1:0] in_awuser,
    input  logic [7:0]          in_awlen,
    input  logic                drop,
    output logic                drop_done
);
    localparam int STRB_WID = DATA_WID / 8;
    localparam int FIFO_W   = DATA_WID + STRB_WID + 1;
    localparam int PTR_W    = (BUF_SZ > 1) ? $clog2(BUF_SZ) : 1;
    localparam int CNT_W    = $clog2(BUF_SZ + 1);

    typedef enum logic [1:0] {ST_PASS, ST_SINK, ST_BRESP} state_t;

    state_t              r_state, w_state_nxt;
    logic                w_swready, w_mbready, w_swready_o, w_mbready_o;
    logic                w_w_acc, w_fifo_push, w_fifo_pop, w_fifo_full, w_fifo_empty;
    logic                w_drop_cap, w_sink_end, w_bloc_load, w_bloc_hs, w_mb_acc;

    logic [FIFO_W-1:0]   r_mem [BUF_SZ];
    logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic [DATA_WID-1:0] r_wdata;
    logic [STRB_WID-1:0] r_wstrb;
    logic                r_wlast, r_mwvalid;

    logic [ID_WID-1:0]   r_bid, r_awid_q;
    logic [1:0]          r_bresp;
    logic [USER_WID-1:0] r_buser, r_awuser_q;
    logic                r_sbvalid, r_bloc;

    logic                r_in_burst, r_drop_pend;
    logic [7:0]          r_cnt, r_awlen_q;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_PASS;
        else       r_state <= w_state_nxt;
    end

    // Once a drop is pending between bursts, W is held off so the faulting burst's
    // first beat can never slip into the FIFO before SINK takes over.
    always_comb begin
        w_state_nxt = r_state;
        w_swready   = 1'b0;
        w_mbready   = 1'b0;
        case (r_state)
            ST_PASS: begin
                w_swready = ~w_fifo_full & ~(r_drop_pend & ~r_in_burst);
                w_mbready = ~r_sbvalid | bus.in_sbready;
                if (r_drop_pend && !r_in_burst) w_state_nxt = ST_SINK;
            end
            ST_SINK: begin
                w_swready = 1'b1;
                w_mbready = ~r_sbvalid | bus.in_sbready;
                if (bus.in_swvalid && r_cnt == r_awlen_q) w_state_nxt = ST_BRESP;
            end
            ST_BRESP: begin
                if (r_bloc && bus.in_sbready) w_state_nxt = ST_PASS;
            end
            default: w_state_nxt = ST_PASS;
        endcase
    end

    assign w_swready_o = w_swready & ~reset;
    assign w_mbready_o = w_mbready & ~reset;
    assign w_w_acc     = bus.in_swvalid & w_swready_o;
    assign w_fifo_push = w_w_acc & (r_state == ST_PASS);
    assign w_fifo_full = (r_count == CNT_W'(BUF_SZ));
    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_pop  = ~w_fifo_empty & (~r_mwvalid | bus.in_mwready);
    assign w_drop_cap  = drop & ~r_drop_pend & (r_state == ST_PASS);
    assign w_sink_end  = (r_state == ST_SINK) & w_w_acc & (r_cnt == r_awlen_q);
    assign w_bloc_load = (r_state == ST_BRESP) & ~r_bloc & (~r_sbvalid | bus.in_sbready);
    assign w_bloc_hs   = (r_state == ST_BRESP) & r_bloc & r_sbvalid & bus.in_sbready;
    assign w_mb_acc    = bus.in_mbvalid & w_mbready_o;

    always_ff @(posedge clk) begin
        if (w_fifo_push) r_mem[r_wr_ptr] <= {bus.in_wdata, bus.in_wstrb, bus.in_wlast};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_fifo_push)
                r_wr_ptr <= (r_wr_ptr == PTR_W'(BUF_SZ - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            if (w_fifo_pop)
                r_rd_ptr <= (r_rd_ptr == PTR_W'(BUF_SZ - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            case ({w_fifo_push, w_fifo_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mwvalid <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_wlast   <= 1'b0;
        end else if (w_fifo_pop) begin
            r_mwvalid <= 1'b1;
            {r_wdata, r_wstrb, r_wlast} <= r_mem[r_rd_ptr];
        end else if (bus.in_mwready) begin
            r_mwvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_burst  <= 1'b0;
            r_drop_pend <= 1'b0;
            r_cnt       <= '0;
            r_awid_q    <= '0;
            r_awuser_q  <= '0;
            r_awlen_q   <= '0;
        end else begin
            if (w_fifo_push) r_in_burst <= ~bus.in_wlast;
            if (w_drop_cap) begin
                r_drop_pend <= 1'b1;
                r_awid_q    <= in_awid;
                r_awuser_q  <= in_awuser;
                r_awlen_q   <= in_awlen;
            end else if (w_sink_end) begin
                r_drop_pend <= 1'b0;
            end
            if (w_sink_end)
                r_cnt <= '0;
            else if ((r_state == ST_SINK) && w_w_acc)
                r_cnt <= r_cnt + 8'd1;
        end
    end

    // r_bloc marks that the B output register holds the locally generated DECERR.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sbvalid <= 1'b0;
            r_bloc    <= 1'b0;
            r_bid     <= '0;
            r_bresp   <= '0;
            r_buser   <= '0;
        end else if (w_bloc_load) begin
            r_sbvalid <= 1'b1;
            r_bloc    <= 1'b1;
            r_bid     <= r_awid_q;
            r_bresp   <= 2'b11;
            r_buser   <= r_awuser_q;
        end else if (w_mb_acc) begin
            r_sbvalid <= 1'b1;
            r_bloc    <= 1'b0;
            r_bid     <= bus.in_bid;
            r_bresp   <= bus.in_bresp;
            r_buser   <= bus.in_buser;
        end else if (r_sbvalid && bus.in_sbready) begin
            r_sbvalid <= 1'b0;
            r_bloc    <= 1'b0;
        end
    end

    assign bus.out_swready = w_swready_o;
    assign bus.out_mbready = w_mbready_o;
    assign bus.out_wdata   = r_wdata;
    assign bus.out_wstrb   = r_wstrb;
    assign bus.out_wlast   = r_wlast;
    assign bus.out_mwvalid = r_mwvalid;
    assign bus.out_bid     = r_bid;
    assign bus.out_bresp   = r_bresp;
    assign bus.out_buser   = r_buser;
    assign bus.out_sbvalid = r_sbvalid;
    assign drop_done       = w_bloc_hs & ~reset;
endmodule

// File: tb/tb_axi_wdata_chs.sv
// Scoreboard bench for axi_wdata_chs: drivers push expected W beats / B responses,
// negedge monitors pop and compare whenever the DUT completes a handshake.
module tb_axi_wdata_chs;
    logic       clk;
    logic       reset;
    logic [7:0] in_awid;
    logic [1:0] in_awuser;
    logic [7:0] in_awlen;
    logic       drop;
    logic       drop_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [36:0] exp_w[$];
    logic [12:0] exp_b[$];

    axi_wdata_chs_if #(.ID_WID(8), .DATA_WID(32), .USER_WID(2)) bus ();

    axi_wdata_chs #(.BUF_SZ(256), .ID_WID(8), .DATA_WID(32), .USER_WID(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .in_awid   (in_awid),
        .in_awuser (in_awuser),
        .in_awlen  (in_awlen),
        .drop      (drop),
        .drop_done (drop_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1 ms, required to finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({bus.out_swready, bus.out_wdata, bus.out_wstrb, bus.out_wlast, bus.out_mwvalid,
                    bus.out_mbready, bus.out_bid, bus.out_bresp, bus.out_buser, bus.out_sbvalid,
                    drop_done});
    endfunction

    always @(negedge clk) begin
        logic [36:0] e;
        if (!reset && bus.out_mwvalid && bus.in_mwready) begin
            if (exp_w.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL w_unexpected: got beat %0h, required no beat",
                         {bus.out_wdata, bus.out_wstrb, bus.out_wlast});
            end else begin
                e = exp_w.pop_front();
                check("w_beat", 64'({bus.out_wdata, bus.out_wstrb, bus.out_wlast}), 64'(e));
            end
        end
    end

    always @(negedge clk) begin
        logic [12:0] e;
        if (!reset && bus.out_sbvalid && bus.in_sbready) begin
            if (exp_b.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL b_unexpected: got id %0h resp %0h, required no response",
                         bus.out_bid, bus.out_bresp);
            end else begin
                e = exp_b.pop_front();
                check("b_resp", 64'({bus.out_bid, bus.out_bresp, bus.out_buser, drop_done}), 64'(e));
            end
        end else if (!reset && drop_done) begin
            n_tests++;
            n_fail++;
            $display("FAIL drop_done_stray: got 1 without B handshake, required 0");
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic l,
                             input bit fwd, output int waited);
        waited = 0;
        bus.in_wdata   = d;
        bus.in_wstrb   = s;
        bus.in_wlast   = l;
        bus.in_swvalid = 1'b1;
        @(negedge clk);
        while (!bus.out_swready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.out_swready) begin
            n_tests++;
            n_fail++;
            $display("FAIL w_send_timeout: swready stayed 0, required 1");
        end else if (fwd) begin
            exp_w.push_back({d, s, l});
        end
        @(posedge clk);
        #1;
        bus.in_swvalid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] id, input logic [1:0] rsp, input logic [1:0] usr);
        int t = 0;
        bus.in_bid     = id;
        bus.in_bresp   = rsp;
        bus.in_buser   = usr;
        bus.in_mbvalid = 1'b1;
        exp_b.push_back({id, rsp, usr, 1'b0});
        @(negedge clk);
        while (!bus.out_mbready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!bus.out_mbready) begin
            n_tests++;
            n_fail++;
            $display("FAIL b_send_timeout: mbready stayed 0, required 1");
        end
        @(posedge clk);
        #1;
        bus.in_mbvalid = 1'b0;
    endtask

    task automatic issue_drop(input logic [7:0] id, input logic [1:0] usr, input logic [7:0] len);
        in_awid   = id;
        in_awuser = usr;
        in_awlen  = len;
        drop      = 1'b1;
        @(posedge clk);
        #1;
        drop = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((exp_w.size() != 0 || exp_b.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (exp_w.size() != 0 || exp_b.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_drain: %0d W / %0d B still pending, required 0",
                     name, exp_w.size(), exp_b.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int total_wait;

        reset          = 1'b1;
        drop           = 1'b0;
        in_awid        = '0;
        in_awuser      = '0;
        in_awlen       = '0;
        bus.in_wdata   = '0;
        bus.in_wstrb   = '0;
        bus.in_wlast   = 1'b0;
        bus.in_swvalid = 1'b0;
        bus.in_mwready = 1'b1;
        bus.in_bid     = '0;
        bus.in_bresp   = '0;
        bus.in_buser   = '0;
        bus.in_mbvalid = 1'b0;
        bus.in_sbready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", out_vec(), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 4-beat burst: first valid two cycles after acceptance, then data 1..4
        send_beat(32'd1, 4'hF, 1'b0, 1'b1, w);
        @(negedge clk);
        check("lat_n1_mwvalid", 64'(bus.out_mwvalid), 64'd0);
        @(negedge clk);
        check("lat_n2_mwvalid", 64'(bus.out_mwvalid), 64'd1);
        @(posedge clk);
        #1;
        for (int i = 2; i <= 4; i++) send_beat(32'(i), 4'hF, (i == 4), 1'b1, w);
        wait_idle("burst4");

        // MC stalled: 257 beats fit (FIFO + output register), the 258th waits
        bus.in_mwready = 1'b0;
        total_wait = 0;
        for (int i = 0; i < 257; i++) begin
            send_beat(32'h1000 + 32'(i), 4'(i), (i % 8 == 7), 1'b1, w);
            total_wait += w;
        end
        check("fill_no_stall", 64'(total_wait), 64'd0);
        bus.in_wdata   = 32'h1000 + 32'd257;
        bus.in_wstrb   = 4'(257);
        bus.in_wlast   = 1'b1;
        bus.in_swvalid = 1'b1;
        repeat (3) @(negedge clk);
        check("full_swready", 64'(bus.out_swready), 64'd0);
        check("full_mw_held", 64'({bus.out_mwvalid, bus.out_wdata}), 64'({1'b1, 32'h1000}));
        @(posedge clk);
        #1;
        bus.in_mwready = 1'b1;
        send_beat(32'h1000 + 32'd257, 4'(257), 1'b1, 1'b1, w);
        wait_idle("full");

        // plain MC B passthrough
        send_b(8'h77, 2'b01, 2'b10);
        wait_idle("bpass");

        // faulting burst of 4 sunk, DECERR with the latched id/user
        issue_drop(8'h5A, 2'b01, 8'd3);
        exp_b.push_back({8'h5A, 2'b11, 2'b01, 1'b1});
        for (int i = 0; i < 4; i++) send_beat(32'hBAD0 + 32'(i), 4'hF, (i == 3), 1'b0, w);
        repeat (2) @(negedge clk);
        check("sink_no_fwd", 64'(bus.out_mwvalid), 64'd0);
        wait_idle("drop4");

        // drop coincides with beat 2: rest of that burst forwarded, next burst sunk
        send_beat(32'h21, 4'hF, 1'b0, 1'b1, w);
        in_awid   = 8'hC3;
        in_awuser = 2'b10;
        in_awlen  = 8'd1;
        drop      = 1'b1;
        send_beat(32'h22, 4'hF, 1'b0, 1'b1, w);
        drop = 1'b0;
        send_beat(32'h23, 4'hF, 1'b0, 1'b1, w);
        send_beat(32'h24, 4'hF, 1'b1, 1'b1, w);
        exp_b.push_back({8'hC3, 2'b11, 2'b10, 1'b1});
        send_beat(32'hE0, 4'hF, 1'b0, 1'b0, w);
        send_beat(32'hE1, 4'hF, 1'b1, 1'b0, w);
        send_beat(32'h25, 4'h5, 1'b1, 1'b1, w);
        wait_idle("dropmid");

        // MC B arrives during BRESP while app stalls B: blocked until DECERR taken
        bus.in_sbready = 1'b0;
        issue_drop(8'h11, 2'b11, 8'd0);
        exp_b.push_back({8'h11, 2'b11, 2'b11, 1'b1});
        send_beat(32'hDEAD, 4'hF, 1'b1, 1'b0, w);
        fork
            send_b(8'h03, 2'b00, 2'b00);
            begin
                repeat (3) @(negedge clk);
                check("bresp_mbready", 64'(bus.out_mbready), 64'd0);
                check("bresp_hold", 64'({bus.out_sbvalid, bus.out_bid, bus.out_bresp, bus.out_buser}),
                      64'({1'b1, 8'h11, 2'b11, 2'b11}));
                @(posedge clk);
                #1;
                bus.in_sbready = 1'b1;
            end
        join
        wait_idle("bresp_block");

        // reset in the middle of a sunk burst
        issue_drop(8'h22, 2'b01, 8'd3);
        send_beat(32'hF0, 4'hF, 1'b0, 1'b0, w);
        send_beat(32'hF1, 4'hF, 1'b0, 1'b0, w);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_outputs", out_vec(), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_swready", 64'(bus.out_swready), 64'd1);
        @(posedge clk);
        #1;
        send_beat(32'hA0, 4'h3, 1'b0, 1'b1, w);
        send_beat(32'hA1, 4'hC, 1'b0, 1'b1, w);
        send_beat(32'hA2, 4'h1, 1'b1, 1'b1, w);
        wait_idle("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
